// File: rtl/fpnew_opgroup_share_pkg.sv
// fpnew_opgroup_share_pkg -- arbitration FSM state type and id-width helper.
// Rev 1.0
`default_nettype none

package fpnew_opgroup_share_pkg;

   typedef enum logic [0:0] {
      SHARE_IDLE = 1'b0,
      SHARE_HOLD = 1'b1
   } share_state_e;

   function automatic int unsigned share_id_width(input int unsigned num_ports);
      return (num_ports > 1) ? $clog2(num_ports) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fpnew_rr_select.sv
// fpnew_rr_select -- round-robin pick of the first request at or after ptr.
// Rev 1.0
`default_nettype none

module fpnew_rr_select
   import fpnew_opgroup_share_pkg::*;
#(
   parameter int unsigned NumReq = 2,
   parameter int unsigned IdW    = share_id_width(NumReq)
) (
   input  logic [NumReq-1:0] req,
   input  logic [IdW-1:0]    ptr,
   output logic [NumReq-1:0] gnt,
   output logic [IdW-1:0]    idx,
   output logic              valid
);

   logic [IdW-1:0] cand;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      cand  = '0;
      for (int k = 0; k < int'(NumReq); k++) begin
         cand = IdW'((int'(ptr) + k) % int'(NumReq));
         if (!valid && req[cand]) begin
            valid     = 1'b1;
            idx       = cand;
            gnt[cand] = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/fpnew_opgroup_share.sv
// fpnew_opgroup_share -- shares one operation-group datapath among NumPorts requesters.
// Rev 1.0
`default_nettype none

module fpnew_opgroup_share
   import fpnew_opgroup_share_pkg::*;
#(
   parameter  int unsigned NumPorts       = 2,
   parameter  int unsigned ReqWidth       = 64,
   parameter  int unsigned RspWidth       = 40,
   parameter  int unsigned MaxOutstanding = 4,
   localparam int unsigned IdW            = share_id_width(NumPorts)
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               flush_i,
   input  logic [NumPorts-1:0]                port_req_valid_i,
   output logic [NumPorts-1:0]                port_req_ready_o,
   input  logic [NumPorts-1:0][ReqWidth-1:0]  port_req_data_i,
   output logic [NumPorts-1:0]                port_rsp_valid_o,
   input  logic [NumPorts-1:0]                port_rsp_ready_i,
   output logic [NumPorts-1:0][RspWidth-1:0]  port_rsp_data_o,
   output logic                               dp_req_valid_o,
   input  logic                               dp_req_ready_i,
   output logic [ReqWidth-1:0]                dp_req_data_o,
   output logic [IdW-1:0]                     dp_req_id_o,
   input  logic                               dp_rsp_valid_i,
   output logic                               dp_rsp_ready_o,
   input  logic [RspWidth-1:0]                dp_rsp_data_i,
   input  logic [IdW-1:0]                     dp_rsp_id_i,
   output logic                               flush_o,
   output logic                               busy_o
);

   localparam int unsigned     CntW   = $clog2(MaxOutstanding + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

   share_state_e        state_q, state_d;
   logic [IdW-1:0]      rr_ptr_q, hold_idx_q;
   logic [CntW-1:0]     cnt_q [NumPorts];

   logic [NumPorts-1:0] eligible, sel_gnt, gnt_oh, rsp_hit, rsp_hs, cnt_nz;
   logic [IdW-1:0]      sel_idx, gnt_idx, next_ptr;
   logic                sel_valid, req_hs, holding;

   fpnew_rr_select #(
      .NumReq (NumPorts),
      .IdW    (IdW)
   ) u_rr_select (
      .req   (eligible),
      .ptr   (rr_ptr_q),
      .gnt   (sel_gnt),
      .idx   (sel_idx),
      .valid (sel_valid)
   );

   assign holding        = (state_q == SHARE_HOLD);
   assign gnt_idx        = holding ? hold_idx_q : sel_idx;
   assign dp_req_valid_o = (holding || sel_valid) && !flush_i && !rst_i;
   assign dp_req_data_o  = port_req_data_i[gnt_idx];
   assign dp_req_id_o    = gnt_idx;
   assign req_hs         = dp_req_valid_o && dp_req_ready_i;
   assign next_ptr       = (gnt_idx == IdW'(NumPorts - 1)) ? '0 : gnt_idx + IdW'(1);
   assign flush_o        = flush_i;
   assign busy_o         = !rst_i && ((|cnt_nz) || holding);

   for (genvar i = 0; i < int'(NumPorts); i++) begin : g_port
      // A held grant keeps its port regardless of the arbiter's current pick.
      assign gnt_oh[i]           = holding ? (hold_idx_q == IdW'(i)) : sel_gnt[i];
      assign eligible[i]         = port_req_valid_i[i] && (cnt_q[i] < CntMax);
      assign port_req_ready_o[i] = req_hs && gnt_oh[i];
      assign cnt_nz[i]           = (cnt_q[i] != '0);
      assign rsp_hit[i]          = (dp_rsp_id_i == IdW'(i)) && cnt_nz[i];
      assign port_rsp_valid_o[i] = dp_rsp_valid_i && rsp_hit[i] && !rst_i;
      assign rsp_hs[i]           = port_rsp_valid_o[i] && port_rsp_ready_i[i];
      assign port_rsp_data_o[i]  = dp_rsp_data_i;

      always_ff @(posedge clk_i) begin
         if (rst_i || flush_i) begin
            cnt_q[i] <= '0;
         end else if (port_req_ready_o[i] && !rsp_hs[i]) begin
            cnt_q[i] <= cnt_q[i] + CntW'(1);
         end else if (!port_req_ready_o[i] && rsp_hs[i]) begin
            cnt_q[i] <= cnt_q[i] - CntW'(1);
         end
      end
   end

   // Unknown or idle ids are swallowed so a stray response can never stall the datapath.
   always_comb begin
      dp_rsp_ready_o = 1'b1;
      for (int i = 0; i < int'(NumPorts); i++) begin
         if (rsp_hit[i]) begin
            dp_rsp_ready_o = port_rsp_ready_i[i];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = SHARE_IDLE;
      end else begin
         case (state_q)
            SHARE_IDLE: if (dp_req_valid_o && !dp_req_ready_i) state_d = SHARE_HOLD;
            SHARE_HOLD: if (dp_req_ready_i)                     state_d = SHARE_IDLE;
            default:                                            state_d = SHARE_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= SHARE_IDLE;
         rr_ptr_q   <= '0;
         hold_idx_q <= '0;
      end else begin
         state_q <= state_d;
         if (req_hs) begin
            rr_ptr_q <= next_ptr;
         end
         if (!holding && dp_req_valid_o && !dp_req_ready_i) begin
            hold_idx_q <= sel_idx;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fpnew_opgroup_share.sv
// tb_fpnew_opgroup_share -- directed and random stimulus against a cycle-level reference model.
// Rev 1.0
`default_nettype none

module tb_fpnew_opgroup_share;

   localparam int NP = 2;
   localparam int RW = 64;
   localparam int SW = 40;
   localparam int MO = 4;

   logic                   clk = 1'b0;
   logic                   rst, flush;
   logic [NP-1:0]          req_valid, req_ready, rsp_valid, rsp_ready;
   logic [NP-1:0][RW-1:0]  req_data;
   logic [NP-1:0][SW-1:0]  rsp_data;
   logic                   dp_req_valid, dp_req_ready, dp_rsp_valid, dp_rsp_ready;
   logic [RW-1:0]          dp_req_data;
   logic [0:0]             dp_req_id, dp_rsp_id;
   logic [SW-1:0]          dp_rsp_data;
   logic                   flush_out, busy;

   int checks   = 0;
   int failures = 0;

   int m_cnt [NP];
   int m_ptr;
   int m_hold;

   always #5 clk = ~clk;

   fpnew_opgroup_share #(
      .NumPorts       (NP),
      .ReqWidth       (RW),
      .RspWidth       (SW),
      .MaxOutstanding (MO)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .flush_i          (flush),
      .port_req_valid_i (req_valid),
      .port_req_ready_o (req_ready),
      .port_req_data_i  (req_data),
      .port_rsp_valid_o (rsp_valid),
      .port_rsp_ready_i (rsp_ready),
      .port_rsp_data_o  (rsp_data),
      .dp_req_valid_o   (dp_req_valid),
      .dp_req_ready_i   (dp_req_ready),
      .dp_req_data_o    (dp_req_data),
      .dp_req_id_o      (dp_req_id),
      .dp_rsp_valid_i   (dp_rsp_valid),
      .dp_rsp_ready_o   (dp_rsp_ready),
      .dp_rsp_data_i    (dp_rsp_data),
      .dp_rsp_id_i      (dp_rsp_id),
      .flush_o          (flush_out),
      .busy_o           (busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Check all outputs for the inputs currently applied, then advance one clock.
   task automatic step();
      int  gid, rid, p;
      bit  exp_dpv, hs, routed, exp_busy;
      #1;
      gid     = -1;
      exp_dpv = 1'b0;
      hs      = 1'b0;
      rid     = int'(dp_rsp_id);
      routed  = (rid < NP) && (m_cnt[rid] > 0);
      chk("flush_o", 64'(flush_out), 64'(flush));
      if (rst) begin
         chk("rst_dp_req_valid", 64'(dp_req_valid), 64'd0);
         chk("rst_port_req_ready", 64'(req_ready), 64'd0);
         chk("rst_port_rsp_valid", 64'(rsp_valid), 64'd0);
         chk("rst_busy", 64'(busy), 64'd0);
      end else begin
         if (m_hold >= 0) begin
            gid = m_hold;
         end else begin
            for (int k = 0; k < NP; k++) begin
               p = (m_ptr + k) % NP;
               if (gid < 0 && req_valid[p] && m_cnt[p] < MO) gid = p;
            end
         end
         exp_dpv = (gid >= 0) && !flush;
         hs      = exp_dpv && dp_req_ready;
         chk("dp_req_valid", 64'(dp_req_valid), 64'(exp_dpv));
         if (exp_dpv) begin
            chk("dp_req_id", 64'(dp_req_id), 64'(gid));
            chk("dp_req_data", dp_req_data, req_data[gid]);
         end
         chk("port_req_ready", 64'(req_ready), hs ? (64'd1 << gid) : 64'd0);
         chk("port_rsp_valid", 64'(rsp_valid), (dp_rsp_valid && routed) ? (64'd1 << rid) : 64'd0);
         chk("dp_rsp_ready", 64'(dp_rsp_ready), routed ? 64'(rsp_ready[rid]) : 64'd1);
         for (int k = 0; k < NP; k++) chk("port_rsp_data", 64'(rsp_data[k]), 64'(dp_rsp_data));
         exp_busy = (m_hold >= 0);
         for (int k = 0; k < NP; k++) if (m_cnt[k] > 0) exp_busy = 1'b1;
         chk("busy", 64'(busy), 64'(exp_busy));
      end

      if (rst) begin
         for (int k = 0; k < NP; k++) m_cnt[k] = 0;
         m_ptr  = 0;
         m_hold = -1;
      end else if (flush) begin
         for (int k = 0; k < NP; k++) m_cnt[k] = 0;
         m_hold = -1;
      end else begin
         if (hs) begin
            m_cnt[gid]++;
            m_ptr  = (gid + 1) % NP;
            m_hold = -1;
         end else if (exp_dpv) begin
            m_hold = gid;
         end
         if (dp_rsp_valid && routed && rsp_ready[rid]) m_cnt[rid]--;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rsp(input bit v, input int id, input logic [NP-1:0] rdy);
      dp_rsp_valid = v;
      dp_rsp_id    = 1'(id);
      rsp_ready    = rdy;
      dp_rsp_data  = {$urandom, $urandom};
   endtask

   initial begin
      for (int k = 0; k < NP; k++) m_cnt[k] = 0;
      m_ptr  = 0;
      m_hold = -1;
      rst          = 1'b1;
      flush        = 1'b0;
      req_valid    = 2'b11;
      dp_req_ready = 1'b1;
      for (int k = 0; k < NP; k++) req_data[k] = {$urandom, $urandom};
      rsp(0, 0, 2'b00);
      @(posedge clk);
      #1;
      step();
      step();

      // Two continuous requesters alternate.
      rst = 1'b0;
      for (int k = 0; k < 4; k++) step();
      req_valid = 2'b00;
      rsp(1, 0, 2'b11); step(); step();
      rsp(1, 1, 2'b11); step(); step();
      rsp(0, 0, 2'b00);

      // Stalled grant to port 1 holds while port 0 arrives.
      req_valid    = 2'b10;
      dp_req_ready = 1'b0;
      step();
      req_valid = 2'b11;
      req_data[0] = {$urandom, $urandom};
      step(); step();
      dp_req_ready = 1'b1;
      step(); step();
      req_valid = 2'b00;
      rsp(1, 0, 2'b11); step();
      rsp(1, 1, 2'b11); step();
      rsp(0, 0, 2'b00);

      // Outstanding limit on port 0.
      req_valid = 2'b01;
      for (int k = 0; k < 5; k++) step();
      rsp(1, 0, 2'b01); step();
      rsp(0, 0, 2'b00); step();
      step();

      // Simultaneous issue and return at count 2.
      req_valid = 2'b00;
      rsp(1, 0, 2'b01); step(); step();
      req_valid = 2'b01; step();
      req_valid = 2'b00; step(); step();
      rsp(0, 0, 2'b00); step();

      // Back-pressured response on port 1, then a stray id.
      req_valid = 2'b10; step();
      req_valid = 2'b00;
      rsp(1, 1, 2'b01); step(); step();
      rsp(1, 1, 2'b11); step();
      rsp(1, 1, 2'b00); step();
      rsp(0, 0, 2'b00);

      // Flush with three in flight, then reset while holding.
      req_valid = 2'b11;
      step(); step(); step();
      req_valid = 2'b00;
      flush = 1'b1; step();
      flush = 1'b0; step();
      req_valid    = 2'b01;
      dp_req_ready = 1'b0;
      step();
      rst = 1'b1; step();
      rst = 1'b0;
      req_valid    = 2'b00;
      dp_req_ready = 1'b1;
      step();

      // Random traffic.
      for (int n = 0; n < 500; n++) begin
         rst          = ($urandom_range(0, 99) == 0);
         flush        = ($urandom_range(0, 31) == 0);
         req_valid    = 2'($urandom);
         dp_req_ready = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < NP; k++) req_data[k] = {$urandom, $urandom};
         rsp(($urandom_range(0, 2) == 0), int'($urandom_range(0, 1)), 2'($urandom));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fpnew_opgroup_share.md
FPNEW_OPGROUP_SHARE -- requirements
Module: fpnew_opgroup_share

Interface
REQ-001 The block SHALL have parameter NumPorts, default 2, number of requesters sharing one operation-group datapath (min 2).
REQ-002 The block SHALL have parameter ReqWidth, default 64, opaque request payload width.
REQ-003 The block SHALL have parameter RspWidth, default 40, opaque response payload width.
REQ-004 The block SHALL have parameter MaxOutstanding, default 4, per-port in-flight limit (min 1).
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 The block SHALL have port clk_i  input  1  clock, all state updates on rising edge.
REQ-007 The block SHALL have port rst_i  input  1  synchronous active-high reset.
REQ-008 The block SHALL have port flush_i  input  1  abort all in-flight operations.
REQ-009 The block SHALL have port port_req_valid_i / port_req_ready_o  input/output  NumPorts  per-port request handshake.
REQ-010 The block SHALL have port port_req_data_i  input  NumPorts x ReqWidth  per-port request payload.
REQ-011 The block SHALL have port port_rsp_valid_o / port_rsp_ready_i  output/input  NumPorts  per-port response handshake.
REQ-012 The block SHALL have port port_rsp_data_o  output  NumPorts x RspWidth  per-port response payload.
REQ-013 The block SHALL have port dp_req_valid_o / dp_req_ready_i  output/input  1  datapath request handshake.
REQ-014 The block SHALL have port dp_req_data_o  output  ReqWidth  and dp_req_id_o  output  IdW  granted payload and port index.
REQ-015 The block SHALL have port dp_rsp_valid_i / dp_rsp_ready_o  input/output  1  datapath response handshake.
REQ-016 The block SHALL have port dp_rsp_data_i  input  RspWidth  and dp_rsp_id_i  input  IdW  result and returned port index.
REQ-017 The block SHALL have port flush_o  output  1  and busy_o  output  1  forwarded flush; in-flight indication.

Function
REQ-018 IdW SHALL be max(1, clog2(NumPorts)); counter width SHALL be clog2(MaxOutstanding+1).
REQ-019 A port SHALL be eligible when port_req_valid_i set and its outstanding count < MaxOutstanding.
REQ-020 FSM states SHALL be IDLE and HOLD; in IDLE, round-robin pick among eligible ports starting at rr_ptr, dp_req_valid_o asserted same cycle (combinational, zero latency).
REQ-021 If dp_req_ready_i=0 while dp_req_valid_o=1, FSM SHALL enter HOLD, freezing granted index; dp_req_data_o/id_o stable until handshake.
REQ-022 On dp request handshake: port_req_ready_o of granted port only SHALL be 1, rr_ptr SHALL become granted+1 modulo NumPorts, FSM SHALL return to IDLE.
REQ-023 Counter of granted port SHALL increment on request handshake, decrement on its response handshake; both same cycle -> unchanged; never overflow or underflow.
REQ-024 Responses SHALL route by dp_rsp_id_i: port_rsp_valid_o[id]=dp_rsp_valid_i, dp_rsp_ready_o=port_rsp_ready_i[id], data broadcast to all ports.
REQ-025 A response with id >= NumPorts or id whose counter is 0 SHALL be accepted and dropped (dp_rsp_ready_o=1, no port valid).
REQ-026 flush_o SHALL equal flush_i combinationally; on flush_i all counters clear, FSM to IDLE, no request handshake that cycle, rr_ptr retained.
REQ-027 busy_o SHALL be 1 when any counter is nonzero or FSM is HOLD.

Reset
REQ-028 rst_i SHALL clear counters, rr_ptr=0, FSM=IDLE; during and after reset port_req_ready_o=0, port_rsp_valid_o=0, dp_req_valid_o=0, busy_o=0.
REQ-029 Reset mid-HOLD SHALL drop the pending grant without handshake.

Structure
REQ-030 Shared-package additions SHALL be the FSM state enum and a helper returning IdW.
REQ-031 Round-robin selection SHALL be one sub-module, fpnew_rr_select (request vector + pointer -> one-hot grant, index, valid).

Verification
REQ-032 Ports 0,1 valid continuously, dp_req_ready_i=1 -> grants alternate 0,1,0,1; ids match.
REQ-033 Port 1 valid, dp_req_ready_i=0 for 3 cycles, port 0 raises valid cycle 2 -> HOLD keeps id=1, payload stable; port 1 handshake cycle 4, then port 0.
REQ-034 MaxOutstanding=4, no responses, port 0 issues 4 -> 5th not granted, port_req_ready_o[0]=0; one response returns -> 5th issued next cycle.
REQ-035 Simultaneous request handshake and response for port 0 at count 2 -> count stays 2.
REQ-036 Response id=1 with port_rsp_ready_i[1]=0 -> dp_rsp_ready_o=0 until ready; stray id with count 0 -> dropped.
REQ-037 flush_i with 3 in flight then rst_i mid-HOLD -> counters 0, busy_o=0 next cycle, flush_o mirrors flush_i.
